// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Front end of the pipeline: walks a program counter through program memory,
// buffers returned words in a 2-entry FIFO and hands them downstream through a
// valid/ready handshake. Branch/jump redirects flush the buffer and restart
// fetching at the target. A misaligned redirect target parks the unit in a
// sticky error state until reset.
//
// Ports
//   clk              single clock, all state updates on its rising edge
//   rst              asynchronous, active-low reset
//   imem_addr        byte address presented to program memory (= fetch_pc)
//   imem_data        word returned by program memory, one cycle after address
//   imem_pc          address echo returned with imem_data
//   redirect_valid   redirect request
//   redirect_target  redirect byte address
//   instr_valid      instr/instr_pc hold a valid fetched instruction
//   instr_ready      downstream accepts when high together with instr_valid
//   instr            fetched instruction word (FIFO head)
//   instr_pc         address of instr (FIFO head)
//   fetch_err        sticky misaligned-redirect error
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned OPD_WIDTH = 32,
    parameter int unsigned PC_WIDTH  = 12,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic [31:0]          imem_data,
    input  logic [OPD_WIDTH-1:0] imem_pc,
    input  logic                 redirect_valid,
    input  logic [OPD_WIDTH-1:0] redirect_target,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [31:0]          instr,
    output logic [OPD_WIDTH-1:0] instr_pc,
    output logic                 fetch_err
);

    localparam int DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [PC_WIDTH-1:0]   fetch_pc_reg, fetch_pc_next;
    logic                  inflight_reg, inflight_next;
    logic                  fetch_err_reg, fetch_err_next;
    logic [1:0]            count_reg, count_next;
    logic                  wr_ptr_reg, wr_ptr_next;
    logic                  rd_ptr_reg, rd_ptr_next;

    logic                  issue;
    logic                  flush;
    logic                  push;
    logic                  pop;
    logic                  pop_eff;
    logic [2:0]            occ_committed;

    logic [31:0]           entry_data [DEPTH];
    logic [OPD_WIDTH-1:0]  entry_pc   [DEPTH];

    // Only the low PC_WIDTH bits and the alignment bits of the target matter.
    logic                  unused_target_hi;
    assign unused_target_hi = ^redirect_target;

    assign pop = instr_valid & instr_ready;

    // Slots already spoken for once this cycle's pop is taken into account:
    // counting the pop lets a new fetch issue every cycle while the consumer
    // keeps up, yet still guarantees the in-flight word always has a slot.
    assign occ_committed = {1'b0, count_reg} - {2'b00, pop} + {2'b00, inflight_reg};

    // ------------------------------------------------------------------
    // Control FSM: next state, fetch decision, flush
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        fetch_err_next = fetch_err_reg;
        issue          = 1'b0;
        flush          = 1'b0;

        unique case (state_reg)
            IDLE: begin
                state_next = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    // Any redirect throws away buffered and in-flight words;
                    // nothing is issued this cycle.
                    flush = 1'b1;
                    if (redirect_target[1:0] != 2'b00) begin
                        state_next     = ERR;
                        fetch_err_next = 1'b1;
                    end else begin
                        fetch_pc_next = redirect_target[PC_WIDTH-1:0];
                    end
                end else if (occ_committed < 3'd2) begin
                    issue         = 1'b1;
                    fetch_pc_next = fetch_pc_reg + PC_WIDTH'(4);
                end
            end
            ERR: begin
                flush = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A response is only accepted if its fetch was issued last cycle and
    // has not been squashed by a redirect/error in the current cycle.
    assign push          = inflight_reg & ~flush;
    assign pop_eff       = pop & ~flush;
    assign inflight_next = issue;

    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            count_next  = 2'd0;
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
        end else begin
            count_next  = count_reg + {1'b0, push} - {1'b0, pop_eff};
            wr_ptr_next = wr_ptr_reg ^ push;
            rd_ptr_next = rd_ptr_reg ^ pop_eff;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            fetch_pc_reg  <= PC_WIDTH'(RESET_PC);
            inflight_reg  <= 1'b0;
            fetch_err_reg <= 1'b0;
            count_reg     <= 2'd0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            inflight_reg  <= inflight_next;
            fetch_err_reg <= fetch_err_next;
            count_reg     <= count_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: one register pair per entry
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0]          data_reg;
            logic [OPD_WIDTH-1:0] pc_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_reg <= '0;
                    pc_reg   <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_reg <= imem_data;
                    pc_reg   <= imem_pc;
                end
            end

            assign entry_data[gi] = data_reg;
            assign entry_pc[gi]   = pc_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr   = fetch_pc_reg;
    assign fetch_err   = fetch_err_reg;
    assign instr_valid = (count_reg != 2'd0);
    // Zeroed while empty so stale entries left behind by a flush never show.
    assign instr       = instr_valid ? entry_data[rd_ptr_reg] : '0;
    assign instr_pc    = instr_valid ? entry_pc[rd_ptr_reg]   : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. A registered-read program memory returns a
// word derived from its address. A reference model tracks which address the
// downstream must see next (sequential +4 with wrap, jumps on aligned
// redirects, silence after a misaligned one) and is compared against the DUT
// on every falling edge. A directed sequence drives the scenarios and checks
// hand-computed addresses and latencies.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] imem_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    instr_fetch #(
        .OPD_WIDTH(32),
        .PC_WIDTH (12),
        .RESET_PC (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .imem_pc        (imem_pc),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_err      (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory contents: address-tagged words, with an all-zero word
    // at byte address 16.
    function automatic logic [31:0] mem_word(input logic [11:0] a);
        if (a == 12'd16) return 32'h0000_0000;
        return {8'hA5, 4'h0, a, 8'h3C};
    endfunction

    always @(posedge clk) begin
        imem_data <= mem_word(imem_addr);
        imem_pc   <= {20'd0, imem_addr};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    int          pe_cnt = 0;   // rising edges since reset release
    logic [11:0] m_exp  = 12'd0;
    logic        m_err  = 1'b0;

    always @(posedge clk) pe_cnt <= rst ? pe_cnt + 1 : 0;

    always @(negedge clk) begin
        if (!rst) begin
            m_exp <= 12'd0;
            m_err <= 1'b0;
        end else begin
            chk("model_fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
            if (m_err || pe_cnt < 3)
                chk("model_no_valid", {31'd0, instr_valid}, 32'd0);
            if (instr_valid) begin
                chk("model_pc", instr_pc, {20'd0, m_exp});
                chk("model_instr", instr, mem_word(m_exp));
            end
            if (instr_valid && instr_ready && !redirect_valid)
                $display("txn pc=%0d instr=%08h", instr_pc, instr);
            if (pe_cnt >= 1 && !m_err && redirect_valid) begin
                if (redirect_target[1:0] != 2'b00) m_err <= 1'b1;
                else                               m_exp <= redirect_target[11:0];
            end else if (instr_valid && instr_ready) begin
                m_exp <= m_exp + 12'd4;
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic exp_instr(input string name, input logic [31:0] pc);
        chk({name, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({name, "_pc"}, instr_pc, pc);
        chk({name, "_instr"}, instr, mem_word(pc[11:0]));
    endtask

    task automatic exp_none(input string name);
        chk({name, "_valid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid  = 1'b1;
        redirect_target = target;
        tick();
        redirect_valid  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({name, "_instr"}, instr, 32'd0);
        chk({name, "_pc"}, instr_pc, 32'd0);
        chk({name, "_err"}, {31'd0, fetch_err}, 32'd0);
        chk({name, "_addr"}, {20'd0, imem_addr}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b0;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;

        #3;
        chk_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b1;

        // Reset release, ready held high: 0,4,8,... back to back.
        tick();                               // IDLE -> RUN edge
        exp_none("idle_exit");
        chk("first_addr", {20'd0, imem_addr}, 32'd0);
        tick();
        exp_none("first_inflight");
        chk("second_addr", {20'd0, imem_addr}, 32'd4);
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_instr("seq", 32'(i * 4));
            if (i == 4) chk("zero_word", instr, 32'd0);
        end

        // pc 24 presented: redirect to 104 drops 24 and in-flight 28.
        do_redirect(32'd104);
        exp_none("redir_gap1");
        chk("redir_addr", {20'd0, imem_addr}, 32'd104);
        tick();
        exp_none("redir_gap2");
        tick();
        exp_instr("redir_first", 32'd104);
        tick();
        exp_instr("redir_next", 32'd108);
        tick();
        exp_instr("redir_next2", 32'd112);

        // Wrap at the top of the 12-bit space.
        do_redirect(32'd4088);
        chk("wrap_addr", {20'd0, imem_addr}, 32'd4088);
        tick();
        tick();
        exp_instr("wrap_a", 32'd4088);
        tick();
        exp_instr("wrap_b", 32'd4092);
        tick();
        exp_instr("wrap_c", 32'd0);
        tick();
        exp_instr("wrap_d", 32'd4);

        // Run up to pc 40 and pulse reset mid-stream.
        do_redirect(32'd32);
        tick();
        tick();
        exp_instr("pre_rst_a", 32'd32);
        tick();
        exp_instr("pre_rst_b", 32'd36);
        tick();
        exp_instr("pre_rst_c", 32'd40);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst = 1'b1;
        tick();
        exp_none("rel_a");
        tick();
        exp_none("rel_b");
        tick();
        exp_instr("rel_first", 32'd0);
        tick();
        exp_instr("rel_second", 32'd4);

        // Back-pressure for 5 cycles while pc 8 is presented.
        tick();
        instr_ready = 1'b0;
        exp_instr("stall_start", 32'd8);
        chk("stall_addr0", {20'd0, imem_addr}, 32'd16);
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_instr("stall_hold", 32'd8);
            chk("stall_addr", {20'd0, imem_addr}, 32'd16);
        end
        tick();
        instr_ready = 1'b1;
        exp_instr("stall_last", 32'd8);
        tick();
        exp_instr("stall_rel_a", 32'd12);
        tick();
        exp_instr("stall_rel_b", 32'd16);
        tick();
        exp_instr("stall_rel_c", 32'd20);

        // Misaligned redirect while pc 20 is presented.
        do_redirect(32'h66);
        chk("err_set", {31'd0, fetch_err}, 32'd1);
        exp_none("err_a");
        tick();
        tick();
        do_redirect(32'd0);                  // must be ignored
        exp_none("err_ignore");
        chk("err_sticky", {31'd0, fetch_err}, 32'd1);
        chk("err_addr_frozen", {20'd0, imem_addr}, 32'd28);
        tick();
        tick();
        exp_none("err_b");
        chk("err_sticky2", {31'd0, fetch_err}, 32'd1);

        // Only reset clears the error.
        rst = 1'b0;
        #1;
        chk_reset_outputs("err_rst");
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        exp_instr("post_err", 32'd0);
        tick();
        exp_instr("post_err2", 32'd4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
